// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared AHB3-Lite encodings and slave FSM state type
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

endpackage

// File: rtl/ahb3lite_be_gen.sv
// rtl/ahb3lite_be_gen.sv - little-endian byte-lane enables and misalignment flag
module ahb3lite_be_gen
  import ahb3lite_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misalign
);

  // Sizes wider than a word produce no lanes; the caller flags them illegal.
  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    case (hsize)
      HSIZE_BYTE:  be = 4'b0001 << addr_lo;
      HSIZE_HWORD: begin
        be       = 4'b0011 << addr_lo;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// rtl/ahb3lite_sram_slave.sv - AHB3-Lite register-array memory slave with wait states and ERROR response
module ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int         AW      = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  slave_state_t          state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  done, done_nxt;
  logic [AW-1:0]         lat_idx;
  logic [3:0]            lat_be;
  logic                  lat_write;
  logic [3:0]            be;
  logic                  misalign;
  logic                  accept;
  logic                  illegal;
  logic                  complete;
  logic                  unused_inputs;
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  assign unused_inputs = ^{HBURST, HPROT};

  ahb3lite_be_gen u_be_gen (
    .hsize    (HSIZE),
    .addr_lo  (HADDR[1:0]),
    .be       (be),
    .misalign (misalign)
  );

  // New address phases are only sampled while this slave is not stalling the bus.
  assign accept = HSEL && HREADY &&
                  (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) &&
                  (state == ST_IDLE || state == ST_ERR2);

  assign illegal = (HSIZE > HSIZE_WORD) || misalign ||
                   (HADDR[HADDR_SIZE-1:2] >= (HADDR_SIZE-2)'(MEM_DEPTH));

  assign complete = done && (state == ST_IDLE);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      done      <= 1'b0;
      lat_idx   <= '0;
      lat_be    <= 4'b0000;
      lat_write <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      if (accept) begin
        lat_idx   <= HADDR[AW+1:2];
        lat_be    <= be;
        lat_write <= HWRITE;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = done;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (state == ST_ERR2) HRESP = HRESP_ERROR;
        state_nxt = ST_IDLE;
        done_nxt  = 1'b0;
        if (accept) begin
          if (illegal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt == 4'd0) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
    endcase
  end

  // Memory is deliberately left out of reset; done is cleared by reset so no write can leak.
  always_ff @(posedge HCLK) begin
    if (complete && lat_write) begin
      for (int i = 0; i < HDATA_SIZE / 8; i++) begin
        if (lat_be[i]) mem[lat_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA = (complete && !lat_write) ? mem[lat_idx] : '0;

endmodule
